// File: rtl/riscv_pl_pkg.sv
// +-----------------------------------------------------------------------------+
// | riscv_pl_pkg : shared types and constants for the memory port arbiter        |
// | Revision     : 1.0                                                           |
// +-----------------------------------------------------------------------------+
`default_nettype none

package riscv_pl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  // A lone eligible requester always wins; on a tie the one not served last wins.
  function automatic logic pick_grant(input logic fetch_ok, input logic data_ok,
                                      input logic last);
    if (fetch_ok && data_ok) begin
      return (last == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (data_ok) begin
      return GRANT_D;
    end else begin
      return GRANT_I;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_timeout_cnt.sv
// +-----------------------------------------------------------------------------+
// | arb_timeout_cnt : 8-bit busy-cycle counter flagging a stalled transaction    |
// | Revision        : 1.0                                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (run) begin
      count <= count + 8'd1;
    end
  end

  // Fires during the busy cycle whose increment would reach the limit.
  assign expired = run && (count == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +-----------------------------------------------------------------------------+
// | mem_port_arbiter : fetch/data arbiter onto one shared memory port            |
// | Optional feature : ARB_TIMEOUT_EN (busy timeout with abort data and err)     |
// | Revision         : 1.0                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import riscv_pl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pl_stall,
  output logic        err
);

  arb_state_t state;
  logic       last_grant;
  logic       timeout;

  // A requester in its completion cycle is not eligible, so it is never re-served.
  wire fetch_ok = if_req & ~if_ready;
  wire data_ok  = d_req & ~d_ready;
  wire grant    = pick_grant(fetch_ok, data_ok, last_grant);

  assign pl_stall = (if_req & ~if_ready) | (d_req & ~d_ready);

`ifdef ARB_TIMEOUT_EN
  arb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .run    ((state != IDLE) && !mem_ack),
    .expired(timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  wire [7:0] unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= 32'd0;
      d_rdata    <= 32'd0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_ok || data_ok) begin
            mem_req <= 1'b1;
            if (grant == GRANT_D) begin
              state     <= BUSY_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state     <= BUSY_I;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= 32'd0;
            end
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            d_ready    <= 1'b1;
            d_rdata    <= mem_we ? 32'd0 : mem_rdata;
            last_grant <= GRANT_D;
          end else if (timeout) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            d_ready    <= 1'b1;
            d_rdata    <= ABORT_DATA;
            last_grant <= GRANT_D;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            if_ready   <= 1'b1;
            if_rdata   <= mem_rdata;
            last_grant <= GRANT_I;
          end else if (timeout) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            if_ready   <= 1'b1;
            if_rdata   <= ABORT_DATA;
            last_grant <= GRANT_I;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
